// File: rtl/ram_trace_pkg.sv
// Shared types and widths for the RAM trace path: tracker FSM states, record field widths
// and the burst-wrap mask helper.
package ram_trace_pkg;

  localparam int unsigned ADDR_W = 23;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned UBLB_W = 2;
  localparam int unsigned TIME_W = 16;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StLatency = 2'd1,
    StBurst   = 2'd2
  } state_e;

  // Bits of the address that roll over inside one burst; 0 means the whole address counts.
  function automatic logic [ADDR_W-1:0] wrap_mask(int unsigned burst_wrap);
    if (burst_wrap == 0) begin
      return '1;
    end
    return ADDR_W'(burst_wrap - 1);
  endfunction

endpackage

// File: rtl/ram_burst_tracker_if.sv
// Filtered RAM bus sample stream in, per-beat trace records out (valid/ready).
// RAM_BURST_TIMESTAMP_EN adds the out_time record field.
interface ram_burst_tracker_if;
  import ram_trace_pkg::*;

  logic [ADDR_W-1:0] filter_a;
  logic [DATA_W-1:0] filter_d;
  logic [UBLB_W-1:0] filter_ublb;
  logic              filter_read;
  logic              filter_write;
  logic              filter_addr_latch;
  logic              filter_strobe;

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic [UBLB_W-1:0] out_ublb;
  logic              out_write;
`ifdef RAM_BURST_TIMESTAMP_EN
  logic [TIME_W-1:0] out_time;

  modport master (
    output filter_a, filter_d, filter_ublb, filter_read, filter_write, filter_addr_latch,
    output filter_strobe, out_ready,
    input  out_valid, out_addr, out_data, out_ublb, out_write, out_time
  );

  modport slave (
    input  filter_a, filter_d, filter_ublb, filter_read, filter_write, filter_addr_latch,
    input  filter_strobe, out_ready,
    output out_valid, out_addr, out_data, out_ublb, out_write, out_time
  );
`else
  modport master (
    output filter_a, filter_d, filter_ublb, filter_read, filter_write, filter_addr_latch,
    output filter_strobe, out_ready,
    input  out_valid, out_addr, out_data, out_ublb, out_write
  );

  modport slave (
    input  filter_a, filter_d, filter_ublb, filter_read, filter_write, filter_addr_latch,
    input  filter_strobe, out_ready,
    output out_valid, out_addr, out_data, out_ublb, out_write
  );
`endif

endinterface

// File: rtl/ram_burst_addr_gen.sv
// Burst word-address generator: loads the latched base, steps per beat, wraps the low
// log2(BURST_WRAP) bits (BURST_WRAP = 0: plain 23-bit increment).
module ram_burst_addr_gen
  import ram_trace_pkg::*;
#(
  parameter int unsigned BURST_WRAP = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] addr_o
);

  localparam logic [ADDR_W-1:0] WrapMask = wrap_mask(BURST_WRAP);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] addr_plus;

  always_comb begin
    addr_plus = addr_q + ADDR_W'(1);
    addr_d    = addr_q;
    if (load_i) begin
      addr_d = base_i;
    end else if (inc_i) begin
      addr_d = (addr_q & ~WrapMask) | (addr_plus & WrapMask);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/ram_burst_tracker.sv
// Reconstructs synchronous-burst PSRAM transactions from strobed bus samples and emits one
// record per data beat. RAM_BURST_TIMESTAMP_EN adds a strobe-count timestamp per record.
module ram_burst_tracker
  import ram_trace_pkg::*;
#(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned BURST_WRAP = 0
) (
  input  logic                mclk,
  input  logic                reset,
  ram_burst_tracker_if.slave  bus,
  input  logic                clear_flags,
  output logic                overflow,
  output logic                proto_err
);

  localparam logic [3:0] LatInit = 4'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [3:0]        lat_cnt_q, lat_cnt_d;
  logic              addr_load, addr_inc, beat, both;
  logic              rec_load, rec_drop;
  logic [ADDR_W-1:0] cur_addr;

  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [UBLB_W-1:0] out_ublb_q, out_ublb_d;
  logic              out_write_q, out_write_d;
  logic              overflow_q, overflow_d;
  logic              proto_err_q, proto_err_d;

  ram_burst_addr_gen #(
    .BURST_WRAP (BURST_WRAP)
  ) u_addr_gen (
    .clk_i  (mclk),
    .rst_ni (reset),
    .load_i (addr_load),
    .base_i (bus.filter_a),
    .inc_i  (addr_inc),
    .addr_o (cur_addr)
  );

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    addr_load = 1'b0;
    addr_inc  = 1'b0;
    beat      = 1'b0;
    both      = 1'b0;
    if (bus.filter_strobe) begin
      if (bus.filter_addr_latch) begin
        state_d   = StLatency;
        lat_cnt_d = LatInit;
        addr_load = 1'b1;
      end else begin
        case (state_q)
          StIdle: ;
          StLatency: begin
            if (lat_cnt_q == 4'd0) begin
              state_d = StBurst;
            end else begin
              lat_cnt_d = lat_cnt_q - 4'd1;
            end
          end
          StBurst: begin
            // A conflicting rd+wr sample still consumes a burst slot on the RAM side.
            if (bus.filter_read ^ bus.filter_write) begin
              beat     = 1'b1;
              addr_inc = 1'b1;
            end else if (bus.filter_read && bus.filter_write) begin
              both     = 1'b1;
              addr_inc = 1'b1;
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_comb begin
    rec_load    = beat && (!out_valid_q || bus.out_ready);
    rec_drop    = beat && out_valid_q && !bus.out_ready;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_ublb_d  = out_ublb_q;
    out_write_d = out_write_q;
    if (rec_load) begin
      out_valid_d = 1'b1;
      out_addr_d  = cur_addr;
      out_data_d  = bus.filter_d;
      out_ublb_d  = bus.filter_ublb;
      out_write_d = bus.filter_write;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    overflow_d  = rec_drop | (overflow_q & ~clear_flags);
    proto_err_d = both | (proto_err_q & ~clear_flags);
  end

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      lat_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_ublb_q  <= '0;
      out_write_q <= 1'b0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_ublb_q  <= out_ublb_d;
      out_write_q <= out_write_d;
      overflow_q  <= overflow_d;
      proto_err_q <= proto_err_d;
    end
  end

`ifdef RAM_BURST_TIMESTAMP_EN
  logic [TIME_W-1:0] ts_q, ts_d;
  logic [TIME_W-1:0] out_time_q, out_time_d;

  always_comb begin
    ts_d       = bus.filter_strobe ? ts_q + TIME_W'(1) : ts_q;
    out_time_d = rec_load ? ts_q : out_time_q;
  end

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      ts_q       <= '0;
      out_time_q <= '0;
    end else begin
      ts_q       <= ts_d;
      out_time_q <= out_time_d;
    end
  end

  assign bus.out_time = out_time_q;
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ublb  = out_ublb_q;
  assign bus.out_write = out_write_q;
  assign overflow      = overflow_q;
  assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_ram_burst_tracker.sv
// Directed bench for ram_burst_tracker: a continuous-burst DUT and an 8-word-wrap DUT share
// one stimulus stream; accepted records are collected per DUT and compared with fixed values.
module tb_ram_burst_tracker;

  typedef struct {
    logic [22:0] a;
    logic [15:0] d;
    logic [1:0]  be;
    logic        w;
    logic [15:0] t;
  } rec_t;

  logic        mclk = 1'b0;
  logic        reset = 1'b0;
  logic        clear_flags = 1'b0;
  logic [22:0] f_a = '0;
  logic [15:0] f_d = '0;
  logic [1:0]  f_ublb = '0;
  logic        f_read = 1'b0, f_write = 1'b0, f_latch = 1'b0, f_strobe = 1'b0;
  logic        ready0 = 1'b1, ready8 = 1'b1;
  logic        overflow0, proto0, overflow8, proto8;

  rec_t q0[$];
  rec_t q8[$];
  int   n_cmp = 0;
  int   n_err = 0;

  ram_burst_tracker_if bus0 ();
  ram_burst_tracker_if bus8 ();

  assign bus0.filter_a = f_a;          assign bus8.filter_a = f_a;
  assign bus0.filter_d = f_d;          assign bus8.filter_d = f_d;
  assign bus0.filter_ublb = f_ublb;    assign bus8.filter_ublb = f_ublb;
  assign bus0.filter_read = f_read;    assign bus8.filter_read = f_read;
  assign bus0.filter_write = f_write;  assign bus8.filter_write = f_write;
  assign bus0.filter_addr_latch = f_latch;
  assign bus8.filter_addr_latch = f_latch;
  assign bus0.filter_strobe = f_strobe;
  assign bus8.filter_strobe = f_strobe;
  assign bus0.out_ready = ready0;
  assign bus8.out_ready = ready8;

  ram_burst_tracker #(.LATENCY(4), .BURST_WRAP(0)) dut0 (
    .mclk        (mclk),
    .reset       (reset),
    .bus         (bus0),
    .clear_flags (clear_flags),
    .overflow    (overflow0),
    .proto_err   (proto0)
  );

  ram_burst_tracker #(.LATENCY(4), .BURST_WRAP(8)) dut8 (
    .mclk        (mclk),
    .reset       (reset),
    .bus         (bus8),
    .clear_flags (clear_flags),
    .overflow    (overflow8),
    .proto_err   (proto8)
  );

  always #5 mclk = ~mclk;

  // Each accept is visible for exactly one cycle, so sampling mid-cycle logs it once.
  always @(negedge mclk) begin
    rec_t r;
    if (bus0.out_valid && bus0.out_ready) begin
      r.a = bus0.out_addr; r.d = bus0.out_data; r.be = bus0.out_ublb; r.w = bus0.out_write;
`ifdef RAM_BURST_TIMESTAMP_EN
      r.t = bus0.out_time;
`else
      r.t = '0;
`endif
      q0.push_back(r);
    end
    if (bus8.out_valid && bus8.out_ready) begin
      r.a = bus8.out_addr; r.d = bus8.out_data; r.be = bus8.out_ublb; r.w = bus8.out_write;
      r.t = '0;
      q8.push_back(r);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic lat, input logic rd, input logic wr,
                        input logic [22:0] a, input logic [15:0] d);
    @(posedge mclk); #1;
    f_latch = lat; f_read = rd; f_write = wr; f_a = a; f_d = d; f_ublb = d[1:0];
    f_strobe = 1'b1;
    @(posedge mclk); #1;
    f_strobe = 1'b0; f_latch = 1'b0; f_read = 1'b0; f_write = 1'b0;
  endtask

  task automatic open_burst(input logic [22:0] a);
    strobe(1'b1, 1'b0, 1'b0, a, 16'h0);
    repeat (4) strobe(1'b0, 1'b0, 1'b0, 23'h0, 16'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic pulse_clear();
    @(posedge mclk); #1 clear_flags = 1'b1;
    @(posedge mclk); #1 clear_flags = 1'b0;
  endtask

  initial begin
    #23 reset = 1'b1;
    idle(2);
    check_eq("rst_valid", 32'(bus0.out_valid), 32'd0);
    check_eq("rst_overflow", 32'(overflow0), 32'd0);
    check_eq("rst_proto", 32'(proto0), 32'd0);
    check_eq("rst_addr", 32'(bus0.out_addr), 32'd0);

    // Read burst, continuous addressing.
    open_burst(23'h012340);
    for (int i = 0; i < 4; i++) strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'hA0 + 16'(i));
    idle(3);
    check_eq("rd_count", q0.size(), 32'd4);
    if (q0.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check_eq($sformatf("rd_addr%0d", i), 32'(q0[i].a), 32'h012340 + i);
        check_eq($sformatf("rd_data%0d", i), 32'(q0[i].d), 32'hA0 + i);
        check_eq($sformatf("rd_ublb%0d", i), 32'(q0[i].be), 32'(i));
        check_eq($sformatf("rd_write%0d", i), 32'(q0[i].w), 32'd0);
`ifdef RAM_BURST_TIMESTAMP_EN
        check_eq($sformatf("rd_time%0d", i), 32'(q0[i].t), 32'd5 + i);
`endif
      end
    end

    // Write burst: 8-word wrap on dut8, continuous on dut0.
    q0.delete(); q8.delete();
    open_burst(23'h000006);
    for (int i = 0; i < 4; i++) strobe(1'b0, 1'b0, 1'b1, 23'h0, 16'hB0 + 16'(i));
    idle(3);
    check_eq("wrap_count", q8.size(), 32'd4);
    if (q8.size() == 4) begin
      check_eq("wrap_addr0", 32'(q8[0].a), 32'h6);
      check_eq("wrap_addr1", 32'(q8[1].a), 32'h7);
      check_eq("wrap_addr2", 32'(q8[2].a), 32'h0);
      check_eq("wrap_addr3", 32'(q8[3].a), 32'h1);
      check_eq("wrap_write", 32'(q8[3].w), 32'd1);
    end
    if (q0.size() == 4) check_eq("nowrap_addr3", 32'(q0[3].a), 32'h9);
    else check_eq("nowrap_count", q0.size(), 32'd4);

    // Wait state inside a burst produces no record and no address step.
    q0.delete();
    open_burst(23'h000100);
    strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'hC0);
    strobe(1'b0, 1'b0, 1'b0, 23'h0, 16'hEE);
    strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'hC1);
    idle(3);
    check_eq("wait_count", q0.size(), 32'd2);
    if (q0.size() == 2) begin
      check_eq("wait_addr0", 32'(q0[0].a), 32'h100);
      check_eq("wait_addr1", 32'(q0[1].a), 32'h101);
      check_eq("wait_data1", 32'(q0[1].d), 32'hC1);
    end

    // Backpressure: first record held, second dropped.
    q0.delete();
    ready0 = 1'b0;
    open_burst(23'h000200);
    strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'h1111);
    check_eq("bp_valid", 32'(bus0.out_valid), 32'd1);
    strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'h2222);
    idle(1);
    check_eq("bp_hold_data", 32'(bus0.out_data), 32'h1111);
    check_eq("bp_hold_addr", 32'(bus0.out_addr), 32'h200);
    check_eq("bp_overflow", 32'(overflow0), 32'd1);
    check_eq("bp_overflow_other", 32'(overflow8), 32'd0);
    ready0 = 1'b1;
    idle(3);
    check_eq("bp_count", q0.size(), 32'd1);
    if (q0.size() == 1) check_eq("bp_acc_data", 32'(q0[0].d), 32'h1111);
    check_eq("bp_valid_after", 32'(bus0.out_valid), 32'd0);
    pulse_clear();
    check_eq("bp_clear", 32'(overflow0), 32'd0);

    // Read+write on one strobe: flagged, dropped, address still advances.
    q0.delete();
    open_burst(23'h000300);
    strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'h0001);
    strobe(1'b0, 1'b1, 1'b1, 23'h0, 16'h0002);
    strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'h0003);
    idle(3);
    check_eq("pe_flag", 32'(proto0), 32'd1);
    check_eq("pe_count", q0.size(), 32'd2);
    if (q0.size() == 2) begin
      check_eq("pe_addr0", 32'(q0[0].a), 32'h300);
      check_eq("pe_addr1", 32'(q0[1].a), 32'h302);
      check_eq("pe_data1", 32'(q0[1].d), 32'h0003);
    end
    pulse_clear();
    check_eq("pe_clear", 32'(proto0), 32'd0);
    clear_flags = 1'b1;
    strobe(1'b0, 1'b1, 1'b1, 23'h0, 16'h0004);
    clear_flags = 1'b0;
    check_eq("pe_set_wins", 32'(proto0), 32'd1);
    pulse_clear();
    check_eq("pe_clear2", 32'(proto0), 32'd0);

    // Reset mid-burst with a pending record.
    q0.delete();
    ready0 = 1'b0;
    open_burst(23'h000400);
    strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'h4444);
    check_eq("mr_valid_before", 32'(bus0.out_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("mr_valid_async", 32'(bus0.out_valid), 32'd0);
    idle(2);
    #3 reset = 1'b1;
    ready0 = 1'b1;
    for (int i = 0; i < 3; i++) strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'h5550 + 16'(i));
    idle(3);
    check_eq("mr_no_records", q0.size(), 32'd0);
    open_burst(23'h000500);
    strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'h6666);
    idle(3);
    check_eq("mr_relatch_count", q0.size(), 32'd1);
    if (q0.size() == 1) check_eq("mr_relatch_addr", 32'(q0[0].a), 32'h500);
`ifdef RAM_BURST_TIMESTAMP_EN
    if (q0.size() == 1) check_eq("mr_time", 32'(q0[0].t), 32'd8);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
